muldiv_unit: RTL



---
 rtl/muldiv_if.sv | 13 +
 rtl/muldiv_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: start/operand/result bundle between the execute stage and the multiply/divide unit
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU producing hi/lo in 35 cycles
module muldiv_unit (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
    state_t state, state_nx;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r, ma, mb, hi_r, lo_r, rem_nx;
    logic [63:0] acc, prod;
    logic [32:0] mul_sum, shifted;
    logic [4:0]  cnt;
    logic        neg_q, neg_r, busy_r, done_r, sgn, is_div, ge;
    assign sgn     = ~op_r[0];
    assign is_div  = op_r[1];
    assign mul_sum = {1'b0, acc[63:32]} + {1'b0, mb[0] ? ma : 32'd0};
    // acc[63:32] is the running remainder; shifting in the next dividend bit forms the 33-bit trial value
    assign shifted = {acc[63:32], ma[31]};
    assign ge      = shifted >= {1'b0, mb};
    assign rem_nx  = ge ? shifted[31:0] - mb : shifted[31:0];
    assign prod    = neg_q ? -acc : acc;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.start ? PREP : IDLE;
            PREP: state_nx = RUN;
            RUN:  state_nx = (cnt == 5'd31) ? FIX : RUN;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            acc    <= '0;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            ma     <= '0;
            mb     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_r <= state_nx != IDLE;
            done_r <= state == FIX;
            case (state)
                IDLE: if (bus.start) begin
                    op_r <= bus.op;
                    a_r  <= bus.a;
                    b_r  <= bus.b;
                end
                PREP: begin
                    ma    <= (sgn && a_r[31]) ? -a_r : a_r;
                    mb    <= (sgn && b_r[31]) ? -b_r : b_r;
                    neg_q <= sgn && (a_r[31] ^ b_r[31]);
                    neg_r <= sgn && a_r[31];
                    acc   <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc <= {rem_nx, acc[30:0], ge};
                        ma  <= ma << 1;
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                        mb  <= mb >> 1;
                    end
                end
                FIX: begin
                    if (!is_div) {hi_r, lo_r} <= prod;
                    else if (b_r == 32'd0) begin
                        hi_r <= a_r;
                        lo_r <= 32'hFFFF_FFFF;
                    end else begin
                        hi_r <= neg_r ? -acc[63:32] : acc[63:32];
                        lo_r <= neg_q ? -acc[31:0] : acc[31:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
